// File: rtl/br_resolve_queue_if.sv
// Handshake bundle between the fetch/execute stages and the branch resolve queue.
// slave = the resolve queue, master = the pipeline driving it.
interface br_resolve_queue_if #(
    parameter int PC_W  = 32,
    parameter int GHR_W = 11,
    parameter int CNT_W = 32
);
    logic             i_flush;
    logic             i_pred_push;
    logic [PC_W-1:0]  i_pred_pc;
    logic [PC_W-1:0]  i_pred_target;
    logic [GHR_W-1:0] i_pred_ghr;
    logic             i_ex_valid;
    logic [PC_W-1:0]  i_ex_pc;
    logic             i_ex_ctrl;
    logic             i_ex_taken;
    logic [PC_W-1:0]  i_ex_target;
    logic [GHR_W-1:0] i_ex_ghr;
    logic             o_full;
    logic             o_redirect;
    logic [PC_W-1:0]  o_redirect_pc;
    logic             o_upd_valid;
    logic [PC_W-1:0]  o_upd_pc;
    logic [GHR_W-1:0] o_upd_ghr;
    logic             o_upd_taken;
    logic [PC_W-1:0]  o_upd_target;
    logic [GHR_W-1:0] o_ghr_restore;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_mis_cnt;
    logic             o_ovf_err;

    modport slave (
        input  i_flush, i_pred_push, i_pred_pc, i_pred_target, i_pred_ghr,
               i_ex_valid, i_ex_pc, i_ex_ctrl, i_ex_taken, i_ex_target, i_ex_ghr,
        output o_full, o_redirect, o_redirect_pc, o_upd_valid, o_upd_pc, o_upd_ghr,
               o_upd_taken, o_upd_target, o_ghr_restore, o_br_cnt, o_mis_cnt, o_ovf_err
    );

    modport master (
        output i_flush, i_pred_push, i_pred_pc, i_pred_target, i_pred_ghr,
               i_ex_valid, i_ex_pc, i_ex_ctrl, i_ex_taken, i_ex_target, i_ex_ghr,
        input  o_full, o_redirect, o_redirect_pc, o_upd_valid, o_upd_pc, o_upd_ghr,
               o_upd_taken, o_upd_target, o_ghr_restore, o_br_cnt, o_mis_cnt, o_ovf_err
    );
endinterface

// File: rtl/br_resolve_queue.sv
// In-order queue of IF predictions, matched against the instruction in EX to
// produce redirects, predictor updates, GHR repair and branch statistics.
module br_resolve_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int GHR_W = 11,
    parameter int CNT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    br_resolve_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Entry storage needs no reset: validity is carried entirely by the pointers.
    logic [PC_W-1:0]  q_pc     [DEPTH];
    logic [PC_W-1:0]  q_target [DEPTH];
    logic [GHR_W-1:0] q_ghr    [DEPTH];

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;

    logic             empty, full, hit, resolve, mis_now, kill, push_ok;
    logic [PC_W-1:0]  head_pc, head_target, pc_plus4, redir_pc;
    logic [GHR_W-1:0] head_ghr, src_ghr;

    assign empty       = (wr_ptr_reg == rd_ptr_reg);
    assign full        = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign bus.o_full  = full;
    assign head_pc     = q_pc[rd_ptr_reg[AW-1:0]];
    assign head_target = q_target[rd_ptr_reg[AW-1:0]];
    assign head_ghr    = q_ghr[rd_ptr_reg[AW-1:0]];
    assign pc_plus4    = bus.i_ex_pc + PC_W'(4);

    always_comb begin
        hit      = bus.i_ex_valid & ~empty & (head_pc == bus.i_ex_pc);
        resolve  = bus.i_ex_valid & (bus.i_ex_ctrl | hit);
        mis_now  = 1'b0;
        redir_pc = pc_plus4;
        if (resolve) begin
            if (bus.i_ex_ctrl && hit) begin
                mis_now  = ~bus.i_ex_taken | (bus.i_ex_target != head_target);
                redir_pc = bus.i_ex_taken ? bus.i_ex_target : pc_plus4;
            end else if (bus.i_ex_ctrl) begin
                // No queued prediction: the fetch went sequential (implicit not-taken).
                mis_now  = bus.i_ex_taken;
                redir_pc = bus.i_ex_target;
            end else begin
                // BTB alias: a non-control instruction was predicted taken.
                mis_now  = 1'b1;
                redir_pc = pc_plus4;
            end
        end
        src_ghr = hit ? head_ghr : bus.i_ex_ghr;

        // While o_redirect is high the fetch stream is still wrong-path.
        kill    = bus.i_flush | bus.o_redirect | mis_now;
        push_ok = bus.i_pred_push & (~full | hit) & ~kill;

        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (bus.i_flush || mis_now) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end else begin
            if (push_ok) wr_ptr_next = wr_ptr_reg + PW'(1);
            if (hit)     rd_ptr_next = rd_ptr_reg + PW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            q_pc[wr_ptr_reg[AW-1:0]]     <= bus.i_pred_pc;
            q_target[wr_ptr_reg[AW-1:0]] <= bus.i_pred_target;
            q_ghr[wr_ptr_reg[AW-1:0]]    <= bus.i_pred_ghr;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_reg        <= '0;
            rd_ptr_reg        <= '0;
            bus.o_redirect    <= 1'b0;
            bus.o_redirect_pc <= '0;
            bus.o_ghr_restore <= '0;
            bus.o_upd_valid   <= 1'b0;
            bus.o_upd_pc      <= '0;
            bus.o_upd_ghr     <= '0;
            bus.o_upd_taken   <= 1'b0;
            bus.o_upd_target  <= '0;
            bus.o_br_cnt      <= '0;
            bus.o_mis_cnt     <= '0;
            bus.o_ovf_err     <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            bus.o_redirect <= mis_now;
            if (resolve) begin
                bus.o_redirect_pc <= redir_pc;
                bus.o_ghr_restore <= {src_ghr[GHR_W-2:0], bus.i_ex_taken};
            end
            bus.o_upd_valid <= bus.i_ex_valid & bus.i_ex_ctrl;
            if (bus.i_ex_valid && bus.i_ex_ctrl) begin
                bus.o_upd_pc     <= bus.i_ex_pc;
                bus.o_upd_ghr    <= src_ghr;
                bus.o_upd_taken  <= bus.i_ex_taken;
                bus.o_upd_target <= bus.i_ex_target;
                if (bus.o_br_cnt != '1)
                    bus.o_br_cnt <= bus.o_br_cnt + CNT_W'(1);
                if (mis_now && bus.o_mis_cnt != '1)
                    bus.o_mis_cnt <= bus.o_mis_cnt + CNT_W'(1);
            end
            // A push that coincides with a pop frees its own slot, so it is not an overflow.
            if (bus.i_pred_push && full && !hit)
                bus.o_ovf_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_br_resolve_queue.sv
// Directed bench for br_resolve_queue: a reference model pushes the expected
// post-edge outputs into a scoreboard, which is popped and checked each cycle.
module tb_br_resolve_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    br_resolve_queue_if #(.PC_W(32), .GHR_W(11), .CNT_W(32)) bus ();

    br_resolve_queue #(.DEPTH(DEPTH), .PC_W(32), .GHR_W(11), .CNT_W(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
        logic [10:0] ghr;
    } ent_t;

    typedef struct {
        logic        redirect;
        logic [31:0] rpc;
        logic [10:0] restore;
        logic        upd_valid;
        logic [31:0] upd_pc;
        logic [10:0] upd_ghr;
        logic        upd_taken;
        logic [31:0] upd_tgt;
        logic [31:0] br;
        logic [31:0] mis;
        logic        ovf;
        logic        full;
    } exp_t;

    ent_t mq[$];
    exp_t sb[$];
    exp_t m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_tests++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic model_reset();
        m = '{default: '0};
        mq.delete();
    endtask

    task automatic idle_inputs();
        bus.i_flush = 0; bus.i_pred_push = 0; bus.i_pred_pc = 0; bus.i_pred_target = 0;
        bus.i_pred_ghr = 0; bus.i_ex_valid = 0; bus.i_ex_pc = 0; bus.i_ex_ctrl = 0;
        bus.i_ex_taken = 0; bus.i_ex_target = 0; bus.i_ex_ghr = 0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] tgt, input logic [10:0] ghr);
        bus.i_pred_push = 1; bus.i_pred_pc = pc; bus.i_pred_target = tgt; bus.i_pred_ghr = ghr;
    endtask

    task automatic ex(input logic [31:0] pc, input logic ctrl, input logic taken,
                      input logic [31:0] tgt, input logic [10:0] ghr);
        bus.i_ex_valid = 1; bus.i_ex_pc = pc; bus.i_ex_ctrl = ctrl;
        bus.i_ex_taken = taken; bus.i_ex_target = tgt; bus.i_ex_ghr = ghr;
    endtask

    // Advance one clock: predict, clock, then compare at the falling edge.
    task automatic cycle();
        logic        hit, resolve, mis, full, kill;
        logic [31:0] rpc;
        logic [10:0] src;
        ent_t        h;
        exp_t        e;
        h = '{default: '0};
        if (mq.size() > 0) h = mq[0];
        hit     = bus.i_ex_valid && (mq.size() > 0) && (h.pc == bus.i_ex_pc);
        resolve = bus.i_ex_valid && (bus.i_ex_ctrl || hit);
        mis = 0;
        rpc = bus.i_ex_pc + 32'd4;
        if (resolve && bus.i_ex_ctrl && hit) begin
            mis = !bus.i_ex_taken || (bus.i_ex_target != h.tgt);
            if (bus.i_ex_taken) rpc = bus.i_ex_target;
        end else if (resolve && bus.i_ex_ctrl) begin
            mis = bus.i_ex_taken;
            rpc = bus.i_ex_target;
        end else if (resolve) begin
            mis = 1;
        end
        src  = hit ? h.ghr : bus.i_ex_ghr;
        full = (mq.size() == DEPTH);
        kill = bus.i_flush || m.redirect || mis;
        if (bus.i_pred_push && full && !hit) m.ovf = 1;
        m.redirect = mis;
        if (resolve) begin
            m.rpc = rpc;
            m.restore = {src[9:0], bus.i_ex_taken};
        end
        m.upd_valid = bus.i_ex_valid && bus.i_ex_ctrl;
        if (m.upd_valid) begin
            m.upd_pc = bus.i_ex_pc; m.upd_ghr = src;
            m.upd_taken = bus.i_ex_taken; m.upd_tgt = bus.i_ex_target;
            if (m.br != 32'hFFFF_FFFF) m.br++;
            if (mis && m.mis != 32'hFFFF_FFFF) m.mis++;
        end
        if (bus.i_flush || mis) mq.delete();
        else begin
            if (hit) void'(mq.pop_front());
            if (bus.i_pred_push && (!full || hit) && !kill)
                mq.push_back('{bus.i_pred_pc, bus.i_pred_target, bus.i_pred_ghr});
        end
        m.full = (mq.size() == DEPTH);
        sb.push_back(m);

        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("redirect", 32'(bus.o_redirect), 32'(e.redirect));
        if (e.redirect) begin
            chk("redirect_pc", bus.o_redirect_pc, e.rpc);
            chk("ghr_restore", 32'(bus.o_ghr_restore), 32'(e.restore));
        end
        chk("upd_valid", 32'(bus.o_upd_valid), 32'(e.upd_valid));
        if (e.upd_valid) begin
            chk("upd_pc", bus.o_upd_pc, e.upd_pc);
            chk("upd_ghr", 32'(bus.o_upd_ghr), 32'(e.upd_ghr));
            chk("upd_taken", 32'(bus.o_upd_taken), 32'(e.upd_taken));
            chk("upd_target", bus.o_upd_target, e.upd_tgt);
        end
        chk("br_cnt", bus.o_br_cnt, e.br);
        chk("mis_cnt", bus.o_mis_cnt, e.mis);
        chk("ovf_err", 32'(bus.o_ovf_err), 32'(e.ovf));
        chk("full", 32'(bus.o_full), 32'(e.full));
        $display("[TB] cycle push=%0b ex=%0b pc=%0h -> redirect=%0b upd=%0b br=%0d mis=%0d full=%0b",
                 bus.i_pred_push, bus.i_ex_valid, bus.i_ex_pc, bus.o_redirect,
                 bus.o_upd_valid, bus.o_br_cnt, bus.o_mis_cnt, bus.o_full);
        idle_inputs();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_redirect"}, 32'(bus.o_redirect), 32'd0);
        chk({tag, "_redirect_pc"}, bus.o_redirect_pc, 32'd0);
        chk({tag, "_upd_valid"}, 32'(bus.o_upd_valid), 32'd0);
        chk({tag, "_upd_pc"}, bus.o_upd_pc, 32'd0);
        chk({tag, "_upd_ghr"}, 32'(bus.o_upd_ghr), 32'd0);
        chk({tag, "_ghr_restore"}, 32'(bus.o_ghr_restore), 32'd0);
        chk({tag, "_br_cnt"}, bus.o_br_cnt, 32'd0);
        chk({tag, "_mis_cnt"}, bus.o_mis_cnt, 32'd0);
        chk({tag, "_ovf_err"}, 32'(bus.o_ovf_err), 32'd0);
        chk({tag, "_full"}, 32'(bus.o_full), 32'd0);
    endtask

    initial begin
        logic [31:0] br_before, mis_before;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1;

        // 1: correctly predicted taken branch
        push(32'h100, 32'h200, 11'h005); cycle();
        cycle();
        ex(32'h100, 1, 1, 32'h200, 11'h7FF); cycle();
        chk("t1_redirect", 32'(bus.o_redirect), 32'd0);
        chk("t1_upd_valid", 32'(bus.o_upd_valid), 32'd1);
        chk("t1_upd_ghr", 32'(bus.o_upd_ghr), 32'h005);
        chk("t1_br_cnt", bus.o_br_cnt, 32'd1);

        // 2: predicted taken, resolves not-taken; push during redirect is dropped
        push(32'h100, 32'h200, 11'h005); cycle();
        ex(32'h100, 1, 0, 32'h104, 11'h000); cycle();
        chk("t2_redirect", 32'(bus.o_redirect), 32'd1);
        chk("t2_redirect_pc", bus.o_redirect_pc, 32'h104);
        chk("t2_ghr_restore", 32'(bus.o_ghr_restore), 32'h00A);
        chk("t2_mis_cnt", bus.o_mis_cnt, 32'd1);
        push(32'h700, 32'h780, 11'h001); cycle();
        ex(32'h700, 0, 0, 32'h0, 11'h000); cycle();
        chk("t2_no_alias", 32'(bus.o_redirect), 32'd0);

        // 3: no queued entry, taken branch -> repair from EX ghr
        ex(32'h300, 1, 1, 32'h380, 11'h401); cycle();
        chk("t3_redirect_pc", bus.o_redirect_pc, 32'h380);
        chk("t3_ghr_restore", 32'(bus.o_ghr_restore), 32'h003);
        chk("t3_upd_ghr", 32'(bus.o_upd_ghr), 32'h401);
        cycle();

        // 4: fill, overflow, push+pop at full, drain
        for (int i = 0; i < DEPTH; i++) begin
            push(32'h1000 + 32'(i * 16), 32'h1040 + 32'(i * 16), 11'(i)); cycle();
        end
        chk("t4_full", 32'(bus.o_full), 32'd1);
        chk("t4_ovf_before", 32'(bus.o_ovf_err), 32'd0);
        push(32'h1040, 32'h1080, 11'h0); cycle();
        chk("t4_ovf", 32'(bus.o_ovf_err), 32'd1);
        push(32'h2000, 32'h2040, 11'h0); ex(32'h1000, 1, 1, 32'h1040, 11'h0); cycle();
        chk("t4_full_pushpop", 32'(bus.o_full), 32'd1);
        for (int i = 1; i < DEPTH; i++) begin
            ex(32'h1000 + 32'(i * 16), 1, 1, 32'h1040 + 32'(i * 16), 11'h0); cycle();
        end
        ex(32'h2000, 1, 1, 32'h2040, 11'h0); cycle();
        chk("t4_drained_nomis", 32'(bus.o_redirect), 32'd0);

        // 5: BTB alias on a non-control instruction
        push(32'h500, 32'h600, 11'h033); cycle();
        br_before = bus.o_br_cnt; mis_before = bus.o_mis_cnt;
        ex(32'h500, 0, 0, 32'h0, 11'h0); cycle();
        chk("t5_redirect_pc", bus.o_redirect_pc, 32'h504);
        chk("t5_upd_valid", 32'(bus.o_upd_valid), 32'd0);
        chk("t5_br_same", bus.o_br_cnt, br_before);
        chk("t5_mis_same", bus.o_mis_cnt, mis_before);
        cycle();

        // 6: flush empties the queue without a redirect
        for (int i = 0; i < 3; i++) begin
            push(32'h800 + 32'(i * 4), 32'h900, 11'h0); cycle();
        end
        bus.i_flush = 1; cycle();
        chk("t6_flush_redirect", 32'(bus.o_redirect), 32'd0);
        ex(32'h800, 1, 1, 32'h900, 11'h0); cycle();
        chk("t6_flushed_miss", 32'(bus.o_redirect), 32'd1);

        // 6b: asynchronous reset mid-stream
        push(32'hA00, 32'hB00, 11'h0); cycle();
        ex(32'hA00, 1, 0, 32'hA04, 11'h0);
        #2 rst_n = 0;
        #1 check_zero("midrst");
        idle_inputs();
        model_reset();
        @(negedge clk);
        rst_n = 1;
        push(32'h100, 32'h200, 11'h005); cycle();
        ex(32'h100, 1, 1, 32'h200, 11'h0); cycle();
        chk("post_rst_br", bus.o_br_cnt, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
